// File: rtl/sensor_poll_sequencer.sv
// Frame scheduler: divides the 1 MHz clock down to the frame rate and, on each
// frame tick, walks the enabled sensor slots with a bounded req/ack handshake.
module sensor_poll_sequencer #(
    parameter int DIV_COUNT = 100000,
    parameter int NUM_SLOTS = 4,
    parameter int TIMEOUT   = 2000
) (
    input  logic                 CLK_1MHZ_IN,
    input  logic                 NSYSRESET,
    input  logic                 ENABLE,
    input  logic [NUM_SLOTS-1:0] SLOT_MASK,
    input  logic [NUM_SLOTS-1:0] ACK,
    input  logic                 ERR_CLR,
    output logic [NUM_SLOTS-1:0] REQ,
    output logic                 FRAME_TICK,
    output logic                 CLK_10HZ_OUT,
    output logic [16:0]          counter,
    output logic                 BUSY,
    output logic [NUM_SLOTS-1:0] TIMEOUT_ERR,
    output logic                 FRAME_OVERRUN,
    output logic [15:0]          FRAME_COUNT
);

    localparam int IW = $clog2(NUM_SLOTS + 1);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [16:0]   CNT_LAST = 17'(DIV_COUNT - 1);
    localparam logic [16:0]   CNT_HALF = 17'(DIV_COUNT / 2);
    localparam logic [WW-1:0] WAIT_MAX = WW'(TIMEOUT);

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_REQ, ST_GAP} state_e;

    state_e               state_q, state_d;
    logic [16:0]          cnt_q, cnt_d;
    logic                 tick_q, tick_d;
    logic                 clk10_q, clk10_d;
    logic [15:0]          frame_count_q, frame_count_d;
    logic [NUM_SLOTS-1:0] mask_q, mask_d;
    logic [NUM_SLOTS-1:0] req_q, req_d;
    logic [NUM_SLOTS-1:0] err_q, err_d, err_set;
    logic                 ovr_q, ovr_d;
    logic                 busy_q, busy_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [IW-1:0]        slot_q, slot_d;
    logic [WW-1:0]        wait_q, wait_d;
    logic                 found;
    logic [IW-1:0]        sel;

    // Timebase runs independently of ENABLE; the square wave and tick are
    // registered from the next counter value so they line up with counter.
    always_comb begin
        cnt_d         = (cnt_q == CNT_LAST) ? 17'd0 : cnt_q + 17'd1;
        tick_d        = (cnt_q == CNT_LAST);
        clk10_d       = (cnt_d < CNT_HALF);
        frame_count_d = tick_d ? frame_count_q + 16'd1 : frame_count_q;
    end

    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!found && mask_q[i] && (IW'(i) >= idx_q)) begin
                found = 1'b1;
                sel   = IW'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        req_d   = req_q;
        idx_d   = idx_q;
        slot_d  = slot_q;
        wait_d  = wait_q;
        err_set = '0;
        case (state_q)
            ST_IDLE: begin
                if (tick_q && ENABLE) begin
                    mask_d = SLOT_MASK;
                    idx_d  = '0;
                    // An empty mask would only bounce through SCAN; stay idle.
                    if (|SLOT_MASK) state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (found) begin
                    req_d   = NUM_SLOTS'(1) << sel;
                    slot_d  = sel;
                    wait_d  = WW'(1);
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (|(req_q & ACK)) begin
                    req_d   = '0;
                    state_d = ST_GAP;
                end else if (wait_q == WAIT_MAX) begin
                    req_d   = '0;
                    err_set = req_q;
                    state_d = ST_GAP;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            ST_GAP: begin
                idx_d   = slot_q + IW'(1);
                state_d = ST_SCAN;
            end
            default: state_d = ST_IDLE;
        endcase
        if (!ENABLE && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            req_d   = '0;
            err_set = '0;
        end
    end

    // Sticky flags: a set on the same edge as a clear survives the clear.
    always_comb begin
        err_d  = (err_q & ~{NUM_SLOTS{ERR_CLR}}) | err_set;
        ovr_d  = (ovr_q & ~ERR_CLR) | (tick_q && state_q != ST_IDLE);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK_1MHZ_IN or negedge NSYSRESET) begin
        if (!NSYSRESET) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            tick_q        <= 1'b0;
            clk10_q       <= 1'b0;
            frame_count_q <= '0;
            mask_q        <= '0;
            req_q         <= '0;
            err_q         <= '0;
            ovr_q         <= 1'b0;
            busy_q        <= 1'b0;
            idx_q         <= '0;
            slot_q        <= '0;
            wait_q        <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            tick_q        <= tick_d;
            clk10_q       <= clk10_d;
            frame_count_q <= frame_count_d;
            mask_q        <= mask_d;
            req_q         <= req_d;
            err_q         <= err_d;
            ovr_q         <= ovr_d;
            busy_q        <= busy_d;
            idx_q         <= idx_d;
            slot_q        <= slot_d;
            wait_q        <= wait_d;
        end
    end

    assign REQ           = req_q;
    assign FRAME_TICK    = tick_q;
    assign CLK_10HZ_OUT  = clk10_q;
    assign counter       = cnt_q;
    assign BUSY          = busy_q;
    assign TIMEOUT_ERR   = err_q;
    assign FRAME_OVERRUN = ovr_q;
    assign FRAME_COUNT   = frame_count_q;

endmodule

// File: tb/tb_sensor_poll_sequencer.sv
// Bench for sensor_poll_sequencer: timebase model plus a scoreboard of expected
// request windows (slot, length, timeout flag) popped as each REQ window closes.
module tb_sensor_poll_sequencer;
    localparam int DIV = 20;
    localparam int NS  = 4;
    localparam int TO  = 5;

    typedef struct {
        int slot;
        int dur;
        int err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          err_clr = 1'b0;
    logic [NS-1:0] mask = '0;
    logic [NS-1:0] ack = '0;
    logic [NS-1:0] REQ, TIMEOUT_ERR;
    logic          FRAME_TICK, CLK_10HZ_OUT, BUSY, FRAME_OVERRUN;
    logic [16:0]   counter;
    logic [15:0]   FRAME_COUNT;

    int checks = 0;
    int errors = 0;
    exp_t sb_q[$];
    int dly[NS];
    int age[NS];
    logic [NS-1:0] stray = '0;

    logic [16:0] m_cnt;
    logic        m_tick, m_live;

    logic [NS-1:0] mon_prev;
    int            mon_run, mon_low, mon_slot;
    exp_t          mon_e;

    always #5 clk = ~clk;

    sensor_poll_sequencer #(.DIV_COUNT(DIV), .NUM_SLOTS(NS), .TIMEOUT(TO)) dut (
        .CLK_1MHZ_IN(clk), .NSYSRESET(rst_n), .ENABLE(en), .SLOT_MASK(mask),
        .ACK(ack), .ERR_CLR(err_clr), .REQ(REQ), .FRAME_TICK(FRAME_TICK),
        .CLK_10HZ_OUT(CLK_10HZ_OUT), .counter(counter), .BUSY(BUSY),
        .TIMEOUT_ERR(TIMEOUT_ERR), .FRAME_OVERRUN(FRAME_OVERRUN),
        .FRAME_COUNT(FRAME_COUNT)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_exp(input int slot, input int dur, input int err);
        exp_t e;
        e.slot = slot; e.dur = dur; e.err = err;
        sb_q.push_back(e);
    endtask

    task automatic wait_tick(input int budget, input string tag);
        int n = 0;
        do begin @(negedge clk); n++; end while (!FRAME_TICK && n < budget);
        chk(tag, FRAME_TICK, 1);
    endtask

    task automatic wait_busy(input logic v, input int budget, input string tag);
        int n = 0;
        do begin @(negedge clk); n++; end while (BUSY !== v && n < budget);
        chk(tag, BUSY, v);
    endtask

    task automatic wait_req(input logic [NS-1:0] v, input int budget, input string tag);
        int n = 0;
        do begin @(negedge clk); n++; end while (REQ !== v && n < budget);
        chk(tag, REQ, v);
    endtask

    // Called at a negedge; makes sure the enable is in place before the next tick is sampled.
    task automatic arm(input logic [NS-1:0] m);
        if (FRAME_TICK) @(negedge clk);
        mask = m;
        en   = 1'b1;
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    // Reference timebase.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt  <= '0;
            m_tick <= 1'b0;
            m_live <= 1'b0;
        end else begin
            m_cnt  <= (m_cnt == 17'(DIV - 1)) ? 17'd0 : m_cnt + 17'd1;
            m_tick <= (m_cnt == 17'(DIV - 1));
            m_live <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_n && m_live) begin
            chk("counter", counter, m_cnt);
            chk("frame_tick", FRAME_TICK, m_tick);
            chk("clk_10hz", CLK_10HZ_OUT, (m_cnt < 17'(DIV / 2)));
        end
    end

    // Sensor reader model: ACK on the dly-th cycle of REQ (0 = never).
    initial begin
        for (int s = 0; s < NS; s++) age[s] = 0;
        forever begin
            @(negedge clk);
            for (int s = 0; s < NS; s++) begin
                age[s] = REQ[s] ? age[s] + 1 : 0;
                ack[s] = stray[s] | (REQ[s] && dly[s] != 0 && age[s] == dly[s]);
            end
        end
    end

    // REQ window monitor.
    initial begin
        mon_prev = '0; mon_run = 0; mon_low = 99;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_prev = '0; mon_run = 0; mon_low = 99;
            end else begin
                chk("req_onehot", $onehot0(REQ), 1);
                if (REQ != mon_prev) begin
                    if (mon_prev != '0) begin
                        mon_slot = 0;
                        for (int i = 0; i < NS; i++) if (mon_prev[i]) mon_slot = i;
                        if (sb_q.size() == 0) begin
                            chk("req_unexpected", sb_q.size(), 1);
                        end else begin
                            mon_e = sb_q.pop_front();
                            chk("req_slot", mon_slot, mon_e.slot);
                            chk("req_len", mon_run, mon_e.dur);
                            chk("tmo_flag", TIMEOUT_ERR[mon_slot], mon_e.err);
                        end
                    end
                    if (REQ != '0) begin
                        chk("req_gap", (mon_low >= 2), 1);
                        mon_run = 1;
                    end
                end else if (REQ != '0) begin
                    mon_run++;
                end
                mon_low = (REQ == '0) ? mon_low + 1 : 0;
                mon_prev = REQ;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        for (int s = 0; s < NS; s++) dly[s] = 0;
        #2;
        chk("rst_req", REQ, 0);
        chk("rst_cnt", counter, 0);
        chk("rst_tick", FRAME_TICK, 0);
        chk("rst_clk10", CLK_10HZ_OUT, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_fcnt", FRAME_COUNT, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Timebase with sequencing disabled.
        repeat (100) @(negedge clk);
        chk("fcount_100", FRAME_COUNT, 5);
        chk("idle_busy", BUSY, 0);

        // Full sweep, ACK on the 3rd cycle of each REQ.
        for (int s = 0; s < NS; s++) begin dly[s] = 3; push_exp(s, 3, 0); end
        arm(4'b1111);
        wait_tick(25, "sweep_tick");
        @(negedge clk);
        chk("sweep_scan_busy", BUSY, 1);
        chk("sweep_scan_req", REQ, 0);
        @(negedge clk);
        chk("sweep_first_req", REQ, 4'b0001);
        wait_busy(1'b0, 40, "sweep_done");
        en = 1'b0;
        chk("sweep_tmo", TIMEOUT_ERR, 0);
        clear_errs();

        // Sparse mask, slot 1 stuck; mask change mid-frame must not matter.
        dly[1] = 0; dly[3] = 1;
        push_exp(1, TO, 1); push_exp(3, 1, 0);
        arm(4'b1010);
        wait_tick(25, "sparse_tick");
        @(negedge clk);
        mask = 4'b1111;
        wait_busy(1'b0, 30, "sparse_done");
        en = 1'b0;
        chk("sparse_tmo", TIMEOUT_ERR, 4'b0010);
        chk("sparse_ovr", FRAME_OVERRUN, 0);

        // Overrun: every slot times out, sequence outlasts the frame.
        clear_errs();
        chk("clr_tmo", TIMEOUT_ERR, 0);
        for (int s = 0; s < NS; s++) begin dly[s] = 0; push_exp(s, TO, 1); end
        arm(4'b1111);
        wait_tick(25, "ovr_tick1");
        wait_tick(25, "ovr_tick2");
        chk("ovr_busy_at_tick", BUSY, 1);
        @(negedge clk);
        chk("ovr_flag", FRAME_OVERRUN, 1);
        wait_busy(1'b0, 30, "ovr_done");
        en = 1'b0;
        chk("ovr_tmo_all", TIMEOUT_ERR, 4'b1111);
        chk("ovr_flag_hold", FRAME_OVERRUN, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("ovr_clr_tmo", TIMEOUT_ERR, 0);
        chk("ovr_clr_flag", FRAME_OVERRUN, 0);

        // Abort by dropping ENABLE while slot 2 is requested.
        dly[0] = 1; dly[1] = 1; dly[2] = 0; dly[3] = 0;
        push_exp(0, 1, 0); push_exp(1, 1, 0); push_exp(2, 1, 0);
        arm(4'b1111);
        wait_req(4'b0100, 60, "abort_req2");
        en = 1'b0;
        @(negedge clk);
        chk("abort_req", REQ, 0);
        chk("abort_busy", BUSY, 0);
        chk("abort_tmo", TIMEOUT_ERR, 0);

        // Asynchronous reset while a request is outstanding.
        arm(4'b0001);
        wait_req(4'b0001, 30, "arst_req");
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req0", REQ, 0);
        chk("arst_busy", BUSY, 0);
        chk("arst_cnt", counter, 0);
        chk("arst_clk10", CLK_10HZ_OUT, 0);
        chk("arst_fcnt", FRAME_COUNT, 0);
        chk("arst_tmo", TIMEOUT_ERR, 0);
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Empty mask never goes busy.
        arm(4'b0000);
        wait_tick(25, "m0_tick");
        repeat (4) begin
            @(negedge clk);
            chk("m0_busy", BUSY, 0);
        end
        en = 1'b0;

        // ACK on the timeout cycle wins; a stray ACK on an idle slot is ignored.
        dly[2] = TO; stray = 4'b0001;
        push_exp(2, TO, 0);
        arm(4'b0100);
        wait_tick(25, "race_tick");
        wait_busy(1'b0, 30, "race_done");
        en = 1'b0;
        stray = '0;
        chk("race_tmo", TIMEOUT_ERR, 0);

        // FRAME_COUNT wrap.
        begin
            int n = 0;
            do begin @(negedge clk); n++; end while (counter != 17'(DIV - 1) && n < 25);
            chk("wrap_sync", counter, DIV - 1);
            force dut.frame_count_q = 16'hFFFF;
            #1 release dut.frame_count_q;
            chk("wrap_pre", FRAME_COUNT, 16'hFFFF);
            @(negedge clk);
            chk("wrap_tick", FRAME_TICK, 1);
            chk("wrap_zero", FRAME_COUNT, 0);
        end

        repeat (3) @(negedge clk);
        chk("sb_drain", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sensor_poll_sequencer.md
Name: sensor_poll_sequencer

Overview:
- Frame scheduler on the 1 MHz system clock.
- Derives the 10 Hz frame timebase: a 17-bit divide counter, a 50% square-wave output and a one-cycle frame tick.
- On each frame tick, walks the enabled sensor slots in ascending order, holding a req/ack handshake with each sensor reader in turn.
- Flags per-slot timeouts and frame overruns so that no single stuck sensor can stall the avionics polling loop.

Parameters:
- DIV_COUNT, 100000: clock cycles per frame (1 MHz / 100000 = 10 Hz); valid range 4..131072.
- NUM_SLOTS, 4: number of sensor requesters.
- TIMEOUT, 2000: maximum number of cycles REQ is held before a slot is abandoned; must be ≥ 1.

Ports:
- CLK_1MHZ_IN, input, 1: system clock, rising edge.
- NSYSRESET, input, 1: asynchronous, active-low reset.
- ENABLE, input, 1: allows frame sequencing.
- SLOT_MASK, input, NUM_SLOTS: per-slot enable; latched at frame start.
- ACK, input, NUM_SLOTS: per-slot completion from the sensor readers.
- ERR_CLR, input, 1: clears the sticky error flags.
- REQ, output, NUM_SLOTS: one-hot level request to a sensor reader.
- FRAME_TICK, output, 1: one-cycle pulse per frame.
- CLK_10HZ_OUT, output, 1: frame-rate square wave.
- counter, output, 17: live divide counter, for debug.
- BUSY, output, 1: high while a frame sequence is active.
- TIMEOUT_ERR, output, NUM_SLOTS: sticky per-slot timeout flags.
- FRAME_OVERRUN, output, 1: sticky; a tick arrived while BUSY.
- FRAME_COUNT, output, 16: number of frames since reset.

Behaviour:
- Reset (asynchronous, NSYSRESET=0): all outputs 0, counter=0, FSM=IDLE.
- Divide counter:
  - counts 0..DIV_COUNT-1 and wraps to 0; runs regardless of ENABLE.
  - FRAME_TICK is registered: high for the one cycle after the counter equals DIV_COUNT-1, i.e. coincident with counter==0.
  - CLK_10HZ_OUT = 1 while counter < DIV_COUNT/2 (integer division), else 0.
- FRAME_COUNT: increments on every FRAME_TICK; wraps from 0xFFFF to 0.
- FSM states are IDLE, SCAN, REQ, GAP.
- IDLE:
  - On FRAME_TICK with ENABLE=1: latch SLOT_MASK into mask_q, set slot index to 0, go to SCAN.
  - If ENABLE=0: the tick is counted and otherwise ignored.
- SCAN (zero-cycle combinational search, or one registered cycle; the cycle count below assumes registered):
  - Find the lowest enabled slot ≥ index.
  - If one is found: assert REQ[slot] on the next cycle and go to REQ.
  - If none is found: go to IDLE.
  - A mask of all zeros returns to IDLE with no REQ pulse.
- BUSY = 1 in SCAN, REQ and GAP.
- REQ: REQ[slot] stays high and wait_cnt increments each cycle.
  - ACK[slot]=1 sampled on an edge: REQ drops on that edge; go to GAP.
  - If wait_cnt reaches TIMEOUT without an ACK: REQ drops, TIMEOUT_ERR[slot] is set, go to GAP.
  - REQ is therefore high for at most TIMEOUT cycles.
  - If ACK and timeout occur on the same cycle, ACK wins; no error is set.
  - ACK on a non-active slot is ignored.
- GAP: one cycle with all REQ low, index = slot+1, then SCAN.
  - This guarantees at least 2 cycles with REQ low between consecutive slots.
- Timing from tick: tick in cycle T, SCAN at T+1, first REQ high at T+2.
- Overrun: FRAME_TICK while BUSY sets FRAME_OVERRUN. The current sequence continues; the tick is dropped, not queued.
- ENABLE falling mid-sequence: on the next edge, REQ goes to 0, the FSM goes to IDLE and no error is flagged.
- SLOT_MASK changes mid-frame have no effect until the next frame.
- ERR_CLR=1: clears TIMEOUT_ERR and FRAME_OVERRUN on that edge. If a set and a clear occur on the same edge, the set wins.
- Reset mid-sequence: REQ drops immediately (asynchronously).
- REQ is never more than one-hot.

Test Plan:
All scenarios use DIV_COUNT=20, TIMEOUT=5, NUM_SLOTS=4.
1. Timebase: release reset, ENABLE=0, run 100 cycles.
   -> FRAME_TICK pulses every 20 cycles, coincident with counter==0.
   -> CLK_10HZ_OUT is high for 10 cycles and low for 10.
   -> FRAME_COUNT=5; REQ stays 0.
2. Full sweep: SLOT_MASK=4'b1111; each ACK responds 2 cycles after its REQ rises.
   -> REQ goes 0001, 0010, 0100, 1000 in order.
   -> Each REQ is high 3 cycles; there are ≥2 idle cycles between REQs.
   -> BUSY drops after slot 3; TIMEOUT_ERR=0.
3. Sparse mask with timeout: SLOT_MASK=4'b1010; slot 1 never ACKs; slot 3 ACKs at once.
   -> REQ[1] is high for exactly 5 cycles, then TIMEOUT_ERR=4'b0010.
   -> REQ[3] then completes; slots 0 and 2 are never requested.
4. Overrun: SLOT_MASK=4'b1111 with all slots timing out (sequence longer than 20 cycles).
   -> FRAME_OVERRUN=1 on the second tick; no restart occurs.
   -> The sequence completes all 4 slots; TIMEOUT_ERR=4'b1111.
   -> ERR_CLR pulse clears all flags.
5. Abort and reset: drop ENABLE while REQ[2] is high.
   -> REQ=0 next cycle, BUSY=0, no error is set.
   -> Separately, assert NSYSRESET mid-REQ: all outputs 0 without a clock edge.
6. Edge cases:
   -> SLOT_MASK=0: BUSY stays 0 and REQ never asserts.
   -> ACK and timeout on the same cycle: no error bit is set.
   -> FRAME_COUNT preloaded by forcing to 0xFFFF wraps to 0.
